// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path: controller state
// encoding, reset address default and instruction field positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_ISSUE = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int IMM_HI    = 15;
  localparam int JIDX_HI   = 25;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-pc selection: jump beats taken branch beats sequential.
// Halting is handled by the caller, which simply does not load the result.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] sel;
  logic        unused_opcode;

  assign pc_plus4  = pc + 32'd4;
  assign br_off    = {{14{instr[IMM_HI]}}, instr[IMM_HI:0], 2'b00};
  assign br_target = pc_plus4 + br_off;
  assign j_target  = {pc_plus4[31:28], instr[JIDX_HI:0], 2'b00};

  // The opcode field plays no part in target arithmetic.
  assign unused_opcode = ^instr[OPCODE_HI:OPCODE_LO];

  always_comb begin
    sel = pc_plus4;
    if (jump) begin
      sel = j_target;
    end else if (branch && zero) begin
      sel = br_target;
    end
  end

  assign next_pc = sel & ~32'd3;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: fetches one word, holds it until the datapath
// retires it, then steers the pc; halts on stop, faults on an imem timeout.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        stop,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  dbg_state
);

  localparam int WCNT_W = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(IMEM_TIMEOUT - 1);

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic [31:0]       next_pc;

  next_pc_calc u_next_pc (
    .pc      (pc),
    .instr   (instr),
    .branch  (branch),
    .zero    (zero),
    .jump    (jump),
    .next_pc (next_pc)
  );

  // imem handshake: imem_req stays high for every FETCH cycle; the read
  // completes on the first rising edge where imem_req && imem_ack, and
  // imem_rdata is captured on that edge. imem_ack without imem_req is dropped.
  // Gating with rst drops the request the moment reset asserts.
  assign imem_req  = rst && (state == ST_FETCH);
  assign imem_addr = pc & ~32'd3;
  assign opcode    = instr_valid ? instr[OPCODE_HI:OPCODE_LO] : 6'b000000;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            wait_cnt    <= '0;
            state       <= ST_ISSUE;
          end else if (wait_cnt == WCNT_LAST) begin
            fault    <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (exec_done) begin
            instr_valid <= 1'b0;
            if (stop) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT:  ;
        ST_FAULT: ;
        default:  state <= ST_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (default and high reset address) share
// stimulus; a behavioural model predicts every output on every cycle.
module tb_fetch_unit;

  localparam int          TMO  = 16;
  localparam logic [31:0] RPC1 = 32'h4000_0010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        imem_ack   = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        exec_done  = 1'b0;
  logic        branch     = 1'b0;
  logic        zero       = 1'b0;
  logic        jump       = 1'b0;
  logic        stop       = 1'b0;

  logic        imem_req_o    [2];
  logic [31:0] imem_addr_o   [2];
  logic [31:0] instr_o       [2];
  logic [5:0]  opcode_o      [2];
  logic        instr_valid_o [2];
  logic [31:0] pc_o          [2];
  logic        halted_o      [2];
  logic        fault_o       [2];
  logic [1:0]  dbg_state_o   [2];

  fetch_unit #(.IMEM_TIMEOUT(TMO)) u_dut0 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_o[0]), .imem_addr(imem_addr_o[0]),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr_o[0]), .opcode(opcode_o[0]), .instr_valid(instr_valid_o[0]),
    .exec_done(exec_done), .branch(branch), .zero(zero), .jump(jump), .stop(stop),
    .pc(pc_o[0]), .halted(halted_o[0]), .fault(fault_o[0]), .dbg_state(dbg_state_o[0])
  );

  fetch_unit #(.RESET_PC(RPC1), .IMEM_TIMEOUT(TMO)) u_dut1 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_o[1]), .imem_addr(imem_addr_o[1]),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr_o[1]), .opcode(opcode_o[1]), .instr_valid(instr_valid_o[1]),
    .exec_done(exec_done), .branch(branch), .zero(zero), .jump(jump), .stop(stop),
    .pc(pc_o[1]), .halted(halted_o[1]), .fault(fault_o[1]), .dbg_state(dbg_state_o[1])
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc [2];
  logic [31:0] m_instr;
  bit          m_valid, m_halted, m_fault;
  int          m_wait;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] target(logic [31:0] p, logic [31:0] ins,
                                         bit br, bit z, bit j);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (br && z) begin
      off = $signed(ins[15:0]);
      return (seq + 32'(off * 4)) & ~32'd3;
    end
    return seq & ~32'd3;
  endfunction

  function automatic bit m_req();
    return rst && !m_valid && !m_halted && !m_fault;
  endfunction

  task automatic model_reset();
    m_pc[0]  = 32'd0;
    m_pc[1]  = RPC1;
    m_instr  = 32'd0;
    m_valid  = 0;
    m_halted = 0;
    m_fault  = 0;
    m_wait   = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.imem_req", k), 32'(imem_req_o[k]), 32'(m_req()));
      chk($sformatf("u%0d.imem_addr", k), imem_addr_o[k], m_pc[k] & ~32'd3);
      chk($sformatf("u%0d.pc", k), pc_o[k], m_pc[k]);
      chk($sformatf("u%0d.instr", k), instr_o[k], m_instr);
      chk($sformatf("u%0d.instr_valid", k), 32'(instr_valid_o[k]), 32'(m_valid));
      chk($sformatf("u%0d.opcode", k), 32'(opcode_o[k]), m_valid ? (m_instr >> 26) : 32'd0);
      chk($sformatf("u%0d.halted", k), 32'(halted_o[k]), 32'(m_halted));
      chk($sformatf("u%0d.fault", k), 32'(fault_o[k]), 32'(m_fault));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(bit ack, logic [31:0] rd, bit ed, bit br, bit z, bit j, bit st);
    compare();
    imem_ack = ack; imem_rdata = rd; exec_done = ed;
    branch = br; zero = z; jump = j; stop = st;
    if (!m_halted && !m_fault) begin
      if (!m_valid) begin
        if (ack) begin
          m_instr = rd; m_valid = 1; m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TMO) m_fault = 1;
        end
      end else if (ed) begin
        m_valid = 0;
        if (st) m_halted = 1;
        else for (int k = 0; k < 2; k++) m_pc[k] = target(m_pc[k], m_instr, br, z, j);
      end
    end
    @(negedge clk);
  endtask

  task automatic fetch_exec(logic [31:0] rd, bit br, bit z, bit j, bit st);
    cycle(1, rd, 0, 0, 0, 0, 0);
    cycle(0, 32'd0, 1, br, z, j, st);
  endtask

  // Asserts reset between edges, checks the asynchronous response, releases.
  task automatic do_reset();
    rst = 1'b0;
    imem_ack = 0; imem_rdata = 32'd0; exec_done = 0;
    branch = 0; zero = 0; jump = 0; stop = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst.u%0d.imem_req", k), 32'(imem_req_o[k]), 32'd0);
      chk($sformatf("rst.u%0d.pc", k), pc_o[k], k == 0 ? 32'd0 : RPC1);
      chk($sformatf("rst.u%0d.instr", k), instr_o[k], 32'd0);
      chk($sformatf("rst.u%0d.valid", k), 32'(instr_valid_o[k]), 32'd0);
      chk($sformatf("rst.u%0d.opcode", k), 32'(opcode_o[k]), 32'd0);
      chk($sformatf("rst.u%0d.halted", k), 32'(halted_o[k]), 32'd0);
      chk($sformatf("rst.u%0d.fault", k), 32'(fault_o[k]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ack_pct;
    @(negedge clk);

    // Jump keeps the region of pc+4.
    do_reset();
    chk("r31_req", 32'(imem_req_o[0]), 32'd1);
    chk("r31_addr", imem_addr_o[1], RPC1);
    fetch_exec(32'h0800_0040, 0, 0, 1, 0);
    chk("r37_addr_hi", imem_addr_o[1], 32'h4000_0100);
    chk("r37_addr_lo", imem_addr_o[0], 32'h0000_0100);

    // Two-cycle ack latency, then branch taken / not taken from 0x10.
    do_reset();
    cycle(0, 32'd0, 0, 0, 0, 0, 0);
    cycle(0, 32'd0, 0, 0, 0, 0, 0);
    cycle(1, 32'h2008_0005, 0, 0, 0, 0, 0);
    chk("r35_valid", 32'(instr_valid_o[0]), 32'd1);
    chk("r35_opcode", 32'(opcode_o[0]), 32'h08);
    chk("r35_pc", pc_o[0], 32'd0);
    chk("r35_addr", imem_addr_o[0], 32'd0);
    cycle(0, 32'd0, 1, 0, 0, 0, 0);
    fetch_exec(32'd0, 0, 0, 0, 0);
    fetch_exec(32'd0, 0, 0, 0, 0);
    fetch_exec(32'd0, 0, 0, 0, 0);
    chk("r36_pc10", pc_o[0], 32'h10);
    fetch_exec(32'h1022_FFFE, 1, 1, 0, 0);
    chk("r36_taken", imem_addr_o[0], 32'h0C);
    chk("r36_taken_hi", imem_addr_o[1], 32'h4000_001C);
    fetch_exec(32'd0, 0, 0, 0, 0);
    fetch_exec(32'h1022_FFFE, 1, 0, 0, 0);
    chk("r36_not_taken", imem_addr_o[0], 32'h14);

    // Backward branch to the top of memory, then sequential wrap.
    do_reset();
    fetch_exec(32'h1000_FFFE, 1, 1, 0, 0);
    chk("r40_top", imem_addr_o[0], 32'hFFFF_FFFC);
    fetch_exec(32'd0, 0, 0, 0, 0);
    chk("r40_wrap", imem_addr_o[0], 32'h0000_0000);
    chk("r40_req", 32'(imem_req_o[0]), 32'd1);

    // Stop beats jump; halt is terminal.
    do_reset();
    cycle(1, 32'hFC00_0000, 0, 0, 0, 0, 0);
    chk("r38_opcode", 32'(opcode_o[0]), 32'h3F);
    cycle(0, 32'd0, 1, 0, 0, 1, 1);
    chk("r38_halted", 32'(halted_o[0]), 32'd1);
    chk("r38_pc", pc_o[1], RPC1);
    repeat (20) cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1));
    chk("r38_req_held", 32'(imem_req_o[0]), 32'd0);

    // Timeout boundary: ack on the last permitted cycle is accepted.
    do_reset();
    repeat (TMO - 1) cycle(0, 32'd0, 0, 0, 0, 0, 0);
    cycle(1, 32'hABCD_1234, 0, 0, 0, 0, 0);
    chk("tmo_edge_fault", 32'(fault_o[0]), 32'd0);
    chk("tmo_edge_instr", instr_o[0], 32'hABCD_1234);

    // Full timeout, then recovery through reset.
    do_reset();
    repeat (TMO) cycle(0, 32'd0, 0, 0, 0, 0, 0);
    chk("r39_fault", 32'(fault_o[0]), 32'd1);
    chk("r39_req", 32'(imem_req_o[0]), 32'd0);
    repeat (4) cycle(1, $urandom, 1, 0, 0, 0, 0);
    do_reset();
    chk("r39_restart", imem_addr_o[0], 32'd0);

    // Reset mid-fetch; the late ack belongs to the new fetch.
    cycle(0, 32'd0, 0, 0, 0, 0, 0);
    cycle(0, 32'd0, 0, 0, 0, 0, 0);
    do_reset();
    cycle(1, 32'h1111_2222, 0, 0, 0, 0, 0);
    chk("r32_instr", instr_o[0], 32'h1111_2222);
    chk("r32_pc", pc_o[1], RPC1);

    // Randomized traffic with varying memory responsiveness.
    ack_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      if ((m_halted || m_fault) && $urandom_range(0, 7) == 0) begin
        do_reset();
        case ($urandom_range(0, 2))
          0: ack_pct = 5;
          1: ack_pct = 40;
          default: ack_pct = 90;
        endcase
      end else begin
        cycle($urandom_range(0, 99) < ack_pct, $urandom,
              $urandom_range(0, 99) < 40, $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) == 0);
      end
    end
    compare();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first instruction address after reset.
REQ-002 SHALL have parameter IMEM_TIMEOUT, default 16, meaning the maximum number of cycles to wait for imem_ack before flagging a fault.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_ack  input  1  read data valid; sampled only while imem_req=1.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-009 SHALL have port instr  output  32  latched instruction.
REQ-010 SHALL have port opcode  output  6  instr[31:26] while instr_valid=1, else 6'b000000; drives the decoder's opcode input.
REQ-011 SHALL have port instr_valid  output  1  instr/opcode hold a fetched, unexecuted instruction.
REQ-012 SHALL have port exec_done  input  1  datapath has completed the current instruction this cycle.
REQ-013 SHALL have ports branch, zero, jump, stop  input  1 each  decoder/ALU outputs for the current instruction.
REQ-014 SHALL have port pc  output  32  address of the current instruction.
REQ-015 SHALL have ports halted, fault  output  1 each  stop executed; imem timeout occurred.

Function
REQ-016 SHALL implement states FETCH, ISSUE, HALT, FAULT; encoding 2 bits.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_ack: instr<=imem_rdata, instr_valid<=1, go to ISSUE next cycle (instr visible one cycle after ack).
REQ-018 A same-cycle ack (ack high in the first FETCH cycle) SHALL be accepted; minimum fetch latency is 1 cycle.
REQ-019 ISSUE: imem_req=0; hold instr, pc until exec_done=1.
REQ-020 On exec_done in ISSUE, next pc SHALL be chosen by priority: stop > jump > (branch & zero) > sequential.
REQ-021 Sequential: pc+4, 32-bit modulo (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-022 Branch target: pc+4 + (sign-extended instr[15:0] << 2), 32-bit modulo.
REQ-023 Jump target: {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-024 Any computed address SHALL have bits [1:0] forced to 0.
REQ-025 exec_done without stop: instr_valid<=0, pc<=target, go to FETCH.
REQ-026 exec_done with stop: pc unchanged, instr_valid<=0, halted<=1, go to HALT; HALT is terminal until reset, imem_req=0.
REQ-027 exec_done, branch, jump, stop SHALL be ignored outside ISSUE.
REQ-028 imem_ack SHALL be ignored when imem_req=0.
REQ-029 A wait counter SHALL count FETCH cycles without ack; reaching IMEM_TIMEOUT SHALL set fault=1, go to FAULT (terminal, imem_req=0).

Reset
REQ-030 While rst=0: pc=RESET_PC, instr=0, instr_valid=0, opcode=0, imem_req=0, halted=0, fault=0, wait counter=0, state=FETCH.
REQ-031 First rising clk after rst deasserts SHALL present imem_req=1, imem_addr=RESET_PC (request driven combinationally from state).
REQ-032 Reset asserted mid-fetch SHALL drop the request immediately; a late ack after reset release SHALL be treated as belonging to the new fetch of RESET_PC.

Structure
REQ-033 State encoding, RESET_PC default and opcode field positions SHALL live in a shared package cpu_pkg.
REQ-034 Target computation SHALL be one combinational sub-module next_pc_calc (inputs pc, instr, branch, zero, jump; output next_pc).

Verification
REQ-035 Reset release, ack after 2 cycles with 32'h2008_0005 -> imem_addr=0, instr_valid=1, opcode=6'b001000, pc=0.
REQ-036 pc=0x10, beq instr imm=16'hFFFE, branch=1, zero=1, exec_done -> next imem_addr=0x0C; with zero=0 -> 0x14.
REQ-037 pc=0x4000_0010, jump=1, instr[25:0]=26'h000_0040, exec_done -> imem_addr=0x4000_0100.
REQ-038 opcode 6'b111111 with stop=1 and jump=1, exec_done -> halted=1, pc unchanged, imem_req stays 0 for 20 cycles.
REQ-039 imem_ack withheld 16 cycles -> fault=1, imem_req=0; rst low then high -> fetch restarts at RESET_PC.
REQ-040 pc=32'hFFFF_FFFC, sequential exec_done -> imem_addr=32'h0000_0000.
